// File: rtl/pp_pipeline_accel_arb_pkg.sv
// Shared types and helpers for the pipeline-accelerator stream arbiters.
// Holds the arbiter state encoding and the rotating-priority pick function.
package pp_pipeline_accel_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int MAX_REQ     = 8;
  localparam int NUM_REQ_DEF = 4;
  localparam int ID_W        = $clog2(NUM_REQ_DEF);

  // First set bit of req scanning last+1, last+2, ... modulo n (n <= MAX_REQ).
  // Scanning from the far end lets the nearest hit overwrite the result.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                         input int last, input int n);
    int idx;
    rr_pick = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      idx = (last + k) % n;
      if (k <= n && req[idx[2:0]]) rr_pick = idx[2:0];
    end
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_fifo_wr_arb_if.sv
// Producer-side and FIFO-side write handshake of the shared stream FIFO arbiter.
// Handshake: a word moves on any cycle where write and full_n are both high; a
// producer holds write and din stable until that happens.
interface pp_pipeline_accel_fifo_wr_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 11
);
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_din;
  logic [NUM_REQ-1:0]            req_full_n;
  logic                          fifo_write;
  logic [DATA_WIDTH-1:0]         fifo_din;
  logic                          fifo_full_n;

  modport master (
    output req_write, req_din, fifo_full_n,
    input  req_full_n, fifo_write, fifo_din
  );

  modport slave (
    input  req_write, req_din, fifo_full_n,
    output req_full_n, fifo_write, fifo_din
  );
endinterface

// File: rtl/pp_pipeline_accel_rr_pick.sv
// Combinational rotating priority encoder: finds the first active request after
// index last, wrapping around. Shared by the read- and write-side arbiters.
module pp_pipeline_accel_rr_pick
  import pp_pipeline_accel_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [MAX_REQ-1:0] req_pad;
  logic [2:0]         pick;

  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = req;
  end

  assign pick  = rr_pick(req_pad, int'(last), N);
  assign found = |req;
  assign idx   = pick[IW-1:0];
endmodule

// File: rtl/pp_pipeline_accel_fifo_wr_arb.sv
// Burst-locked round-robin write arbiter in front of one shared ap_fifo stream.
// The granted producer sees the FIFO's full_n directly, so data passes with zero latency.
module pp_pipeline_accel_fifo_wr_arb
  import pp_pipeline_accel_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 11,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int GW        = $clog2(NUM_REQ),
  localparam int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  pp_pipeline_accel_fifo_wr_arb_if.slave bus,
  output logic                 grant_valid,
  output logic [GW-1:0]        grant_id,
  output logic [CNT_WIDTH-1:0] accept_cnt,
  output arb_state_e           state_dbg,
  output logic [BW-1:0]        burst_cnt_dbg
);
  arb_state_e    state;
  logic [GW-1:0] rr_last;
  logic [BW-1:0] burst_cnt;
  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          accept;
  logic          release_now;

  pp_pipeline_accel_rr_pick #(.N(NUM_REQ), .IW(GW)) u_pick (
    .req   (bus.req_write),
    .last  (rr_last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Held low during reset so a grant being torn down cannot slip a word out.
  always_comb begin
    bus.req_full_n = '0;
    if (grant_valid && bus.fifo_full_n && enable && !reset)
      bus.req_full_n[grant_id] = 1'b1;
  end

  assign accept         = bus.req_write[grant_id] & bus.req_full_n[grant_id];
  assign bus.fifo_write = accept;
  assign bus.fifo_din   = bus.req_din[grant_id*DATA_WIDTH +: DATA_WIDTH];

  assign release_now = !enable || !bus.req_write[grant_id] ||
                       (accept && burst_cnt == BW'(MAX_BURST - 1));

  assign state_dbg     = state;
  assign burst_cnt_dbg = burst_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      burst_cnt   <= '0;
      accept_cnt  <= '0;
      rr_last     <= GW'(NUM_REQ - 1);
    end else begin
      if (accept) accept_cnt <= accept_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (enable && pick_found) begin
            grant_id    <= pick_idx;
            grant_valid <= 1'b1;
            burst_cnt   <= '0;
            state       <= LOCKED;
          end
        end
        LOCKED: begin
          if (release_now) begin
            grant_valid <= 1'b0;
            rr_last     <= grant_id;
            burst_cnt   <= '0;
            state       <= IDLE;
          end else if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/pp_pipeline_accel_fifo_wr_arb.md
Name: pp_pipeline_accel_fifo_wr_arb

Overview:
- Round-robin write arbiter sharing one shallow ap_fifo-style stream FIFO (write/din/full_n handshake) among NUM_REQ HLS producer processes.
- Sits between producers and the shared FIFO's write port. Presents each producer its own full_n, mirroring the FIFO handshake.
- Grants are burst-locked so consecutive words from one producer stay contiguous.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_WIDTH, 11, stream word width.
- MAX_BURST, 4, max words accepted per grant (1..16).
- CNT_WIDTH, 16, width of accepted-word counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  arbitration enable; low blocks all acceptance.
- req_write  in  NUM_REQ  per-producer write strobe.
- req_din  in  NUM_REQ*DATA_WIDTH  producer data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_full_n  out  NUM_REQ  per-producer ready.
- fifo_write  out  1  write strobe to shared FIFO.
- fifo_din  out  DATA_WIDTH  data to shared FIFO.
- fifo_full_n  in  1  shared FIFO not-full.
- grant_valid  out  1  a grant is held.
- grant_id  out  $clog2(NUM_REQ)  index of granted producer.
- accept_cnt  out  CNT_WIDTH  total words written to the FIFO; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset values:
  - state IDLE; grant_valid=0; grant_id=0; burst_cnt=0; accept_cnt=0.
  - rr_last=NUM_REQ-1, so the first search starts at requester 0.
  - All req_full_n=0; fifo_write=0.
- Combinational handshake, zero data latency:
  - req_full_n[i] = grant_valid & (grant_id==i) & fifo_full_n & enable.
  - accept = req_write[grant_id] & req_full_n[grant_id].
  - fifo_write = accept.
  - fifo_din = req_din slice of grant_id. The slice is driven even when not writing.
- Non-granted producers always see full_n=0. Their req_write is ignored and must hold its data, per the ap_fifo protocol.
- State IDLE:
  - If enable=1 and any req_write is high, pick the first requester with req_write=1 scanning rr_last+1, rr_last+2, ... modulo NUM_REQ.
  - Register grant_id, set grant_valid=1, burst_cnt=0, go to LOCKED.
  - Arbitration latency is 1 cycle: no word is accepted in the grant cycle.
- State LOCKED, evaluated each cycle:
  - Release conditions, any one of:
    - enable=0;
    - req_write[grant_id]=0 (producer idle);
    - accept with burst_cnt==MAX_BURST-1.
  - On release: grant_valid=0, rr_last=grant_id, burst_cnt=0, go to IDLE. A word accepted in the release cycle is still written.
  - Else, on accept: burst_cnt++.
  - Else (FIFO full stall): hold grant and burst_cnt unchanged. The stall does not count toward the burst.
- Every release costs one bubble cycle (IDLE) before the next grant. Peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
- accept_cnt increments by 1 on every accept and wraps to 0 after 2^CNT_WIDTH-1.
- Reset mid-burst: grant is dropped the next cycle and no write is issued. Any partially sent burst is not replayed; producers rely on their own handshake.
- MAX_BURST=1: release after every accepted word; strict word-level round-robin.
- Simultaneous requests are resolved only by the rotating pointer; there are no fixed priorities. Fairness bound: any continuously requesting producer is granted within NUM_REQ-1 other grants.

Decomposition:
- Shared package pp_pipeline_accel_arb_pkg holds:
  - state enum {IDLE, LOCKED};
  - function rr_pick(req, last) returning the next index;
  - localparam ID_W = $clog2(NUM_REQ).
- One natural sub-module: pp_pipeline_accel_rr_pick, a combinational rotating priority encoder (req, last -> found, idx), reusable by read-side arbiters.
- The FSM, burst counter and data mux stay in the top module.

Test Plan:
- After reset, all four producers assert with enable=1 and fifo_full_n=1, MAX_BURST=4.
  - Grants go 0,1,2,3,0.
  - Each grant writes 4 words.
  - One idle cycle separates bursts.
  - accept_cnt=16 after the first round.
- Only producer 2 requests, sending 10 words.
  - Bursts of 4,4,2, with a bubble after each.
  - grant_id stays 2 throughout.
  - Data order is preserved.
- Producer 1 is granted and fifo_full_n is low for 3 cycles after word 2.
  - fifo_write=0 during the stall and burst_cnt holds.
  - Words 3-4 are written after the stall; release happens after word 4.
- Producer 0 deasserts req_write after 1 word while producer 3 waits.
  - Release in that cycle; rr_last=0.
  - Next grant goes to producer 3 after a 1-cycle bubble.
- enable drops mid-burst (1 word sent): all req_full_n go 0 immediately and grant_valid goes 0 the next cycle. Reasserting enable re-arbitrates.
- reset asserted during LOCKED with accept_cnt=0xFFFF (accept_cnt wrap/reset check).
  - Before reset: one more accept wraps accept_cnt to 0.
  - Reset: next cycle grant_valid=0, grant_id=0, accept_cnt=0, and no spurious fifo_write.
